// File: rtl/ps2_scan_decoder.sv
// PS/2 scan-code set 2 decoder: synchronizes the converter byte strobe and folds
// E0/F0 prefixes into single key events. Optional timeout: PS2_DECODE_TIMEOUT_EN.
module ps2_scan_decoder #(
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_ready,
  input  logic [7:0] scan_code,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_release,
  output logic       overflow,
  output logic [7:0] last_make
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_E0   = 2'd1,
    ST_F0   = 2'd2,
    ST_E0F0 = 2'd3
  } state_t;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  logic       s1_q, s2_q, s2_prev_q;
  logic       strobe_q, strobe_d;
  logic [7:0] byte_q, byte_d;

  state_t     state_q, state_d;
  logic       emit_s, emit_ext_s, emit_rel_s;
  logic       accept_s;
  logic       tmo_expire_s;

  logic       evt_valid_q, evt_valid_d;
  logic [7:0] evt_code_q, evt_code_d;
  logic       evt_ext_q, evt_ext_d;
  logic       evt_release_q, evt_release_d;
  logic       overflow_q, overflow_d;
  logic [7:0] last_make_q, last_make_d;

  // Byte strobe is registered together with the byte so the FSM sees a clean one-cycle pulse.
  always_comb begin
    strobe_d = s2_q & ~s2_prev_q;
    if (strobe_d) begin
      byte_d = scan_code;
    end else begin
      byte_d = byte_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s2_prev_q <= 1'b0;
      strobe_q  <= 1'b0;
      byte_q    <= 8'h00;
    end else begin
      s1_q      <= scan_ready;
      s2_q      <= s1_q;
      s2_prev_q <= s2_q;
      strobe_q  <= strobe_d;
      byte_q    <= byte_d;
    end
  end

`ifdef PS2_DECODE_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    if (strobe_q || (state_q == ST_IDLE)) begin
      tmo_cnt_d = {CNT_W{1'b0}};
    end else begin
      tmo_cnt_d = tmo_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    tmo_expire_s = (state_q != ST_IDLE) && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_q <= {CNT_W{1'b0}};
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT_CYCLES != 0);
  assign tmo_expire_s     = 1'b0;
`endif

  // Prefix FSM; a strobe takes priority over a simultaneous timeout expiry.
  always_comb begin
    state_d    = state_q;
    emit_s     = 1'b0;
    emit_ext_s = 1'b0;
    emit_rel_s = 1'b0;
    if (strobe_q) begin
      case (state_q)
        ST_IDLE: begin
          if (byte_q == PFX_EXT) begin
            state_d = ST_E0;
          end else if (byte_q == PFX_BRK) begin
            state_d = ST_F0;
          end else begin
            emit_s  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_E0: begin
          if (byte_q == PFX_BRK) begin
            state_d = ST_E0F0;
          end else if (byte_q == PFX_EXT) begin
            state_d = ST_E0;
          end else begin
            emit_s     = 1'b1;
            emit_ext_s = 1'b1;
            state_d    = ST_IDLE;
          end
        end
        ST_F0: begin
          if (byte_q == PFX_BRK) begin
            state_d = ST_F0;
          end else if (byte_q == PFX_EXT) begin
            state_d = ST_E0;
          end else begin
            emit_s     = 1'b1;
            emit_rel_s = 1'b1;
            state_d    = ST_IDLE;
          end
        end
        ST_E0F0: begin
          if (byte_q == PFX_EXT) begin
            state_d = ST_E0;
          end else if (byte_q == PFX_BRK) begin
            state_d = ST_F0;
          end else begin
            emit_s     = 1'b1;
            emit_ext_s = 1'b1;
            emit_rel_s = 1'b1;
            state_d    = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if (tmo_expire_s) begin
      state_d = ST_IDLE;
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output register: a new event may overwrite only an empty or departing slot.
  always_comb begin
    accept_s      = evt_valid_q & evt_ready;
    evt_valid_d   = evt_valid_q;
    evt_code_d    = evt_code_q;
    evt_ext_d     = evt_ext_q;
    evt_release_d = evt_release_q;
    overflow_d    = overflow_q;
    last_make_d   = last_make_q;
    if (emit_s) begin
      if (!evt_valid_q || accept_s) begin
        evt_valid_d   = 1'b1;
        evt_code_d    = byte_q;
        evt_ext_d     = emit_ext_s;
        evt_release_d = emit_rel_s;
      end else begin
        overflow_d = 1'b1;
      end
      if (!emit_rel_s) begin
        last_make_d = byte_q;
      end else begin
        last_make_d = last_make_q;
      end
    end else if (accept_s) begin
      evt_valid_d = 1'b0;
    end else begin
      evt_valid_d = evt_valid_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_valid_q   <= 1'b0;
      evt_code_q    <= 8'h00;
      evt_ext_q     <= 1'b0;
      evt_release_q <= 1'b0;
      overflow_q    <= 1'b0;
      last_make_q   <= 8'h00;
    end else begin
      evt_valid_q   <= evt_valid_d;
      evt_code_q    <= evt_code_d;
      evt_ext_q     <= evt_ext_d;
      evt_release_q <= evt_release_d;
      overflow_q    <= overflow_d;
      last_make_q   <= last_make_d;
    end
  end

  assign evt_valid   = evt_valid_q;
  assign evt_code    = evt_code_q;
  assign evt_ext     = evt_ext_q;
  assign evt_release = evt_release_q;
  assign overflow    = overflow_q;
  assign last_make   = last_make_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Self-checking bench for ps2_scan_decoder: vector table, hand-written corner
// sequences, and random byte streams against a prefix-flag reference model.
module tb_ps2_scan_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       scan_ready;
  logic [7:0] scan_code;
  logic       evt_ready;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_release;
  logic       overflow;
  logic [7:0] last_make;

  int errors = 0;
  int checks = 0;

  // Observed events packed as {ext, release, code}.
  logic [9:0] obs_q[$];
  logic [9:0] exp_q[$];

  typedef struct {
    int         n;
    logic [7:0] b[4];
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } vec_t;

  vec_t vecs[11];

  // Reference model state: pending prefix flags.
  logic m_ext, m_brk;
  logic [7:0] m_last_make;

  ps2_scan_decoder #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .scan_ready(scan_ready), .scan_code(scan_code),
    .evt_ready(evt_ready), .evt_valid(evt_valid), .evt_code(evt_code),
    .evt_ext(evt_ext), .evt_release(evt_release), .overflow(overflow),
    .last_make(last_make)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) obs_q.push_back({evt_ext, evt_release, evt_code});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    scan_code  = b;
    scan_ready = 1'b1;
    repeat (5) @(negedge clk);
    scan_ready = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  // Feed one byte through the reference model.
  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) begin
      m_ext = 1'b1;
      m_brk = 1'b0;
    end else if (b == 8'hF0) begin
      m_ext = m_ext && !m_brk;
      m_brk = 1'b1;
    end else begin
      exp_q.push_back({m_ext, m_brk, b});
      if (!m_brk) m_last_make = b;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic compare_events(input string name);
    check({name, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check({name, "_event"}, {22'd0, obs_q[i]}, {22'd0, exp_q[i]});
    end
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_valid"}, {31'd0, evt_valid}, 32'd0);
    check({name, "_code"}, {24'd0, evt_code}, 32'd0);
    check({name, "_ext"}, {31'd0, evt_ext}, 32'd0);
    check({name, "_rel"}, {31'd0, evt_release}, 32'd0);
    check({name, "_ovf"}, {31'd0, overflow}, 32'd0);
    check({name, "_last"}, {24'd0, last_make}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1, '{8'h1C, 8'h00, 8'h00, 8'h00}, 8'h1C, 1'b0, 1'b0};
    vecs[1]  = '{2, '{8'hF0, 8'h1C, 8'h00, 8'h00}, 8'h1C, 1'b0, 1'b1};
    vecs[2]  = '{2, '{8'hE0, 8'h75, 8'h00, 8'h00}, 8'h75, 1'b1, 1'b0};
    vecs[3]  = '{3, '{8'hE0, 8'hF0, 8'h75, 8'h00}, 8'h75, 1'b1, 1'b1};
    vecs[4]  = '{1, '{8'hE1, 8'h00, 8'h00, 8'h00}, 8'hE1, 1'b0, 1'b0};
    vecs[5]  = '{1, '{8'hAA, 8'h00, 8'h00, 8'h00}, 8'hAA, 1'b0, 1'b0};
    vecs[6]  = '{2, '{8'hF0, 8'hFA, 8'h00, 8'h00}, 8'hFA, 1'b0, 1'b1};
    vecs[7]  = '{3, '{8'hF0, 8'hE0, 8'h75, 8'h00}, 8'h75, 1'b1, 1'b0};
    vecs[8]  = '{3, '{8'hF0, 8'hF0, 8'h1C, 8'h00}, 8'h1C, 1'b0, 1'b1};
    vecs[9]  = '{3, '{8'hE0, 8'hE0, 8'h6B, 8'h00}, 8'h6B, 1'b1, 1'b0};
    vecs[10] = '{4, '{8'hE0, 8'hF0, 8'hF0, 8'h2A}, 8'h2A, 1'b0, 1'b1};

    reset      = 1'b1;
    scan_ready = 1'b0;
    scan_code  = 8'h00;
    evt_ready  = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clk);

    // Exact latency: rising edge N samples scan_ready, evt_valid at edge N+3, one pulse.
    scan_code  = 8'h1C;
    scan_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("lat_n2_valid", {31'd0, evt_valid}, 32'd0);
    @(negedge clk);
    check("lat_n3_valid", {31'd0, evt_valid}, 32'd1);
    check("lat_code", {24'd0, evt_code}, 32'h1C);
    check("lat_flags", {30'd0, evt_ext, evt_release}, 32'd0);
    check("lat_last_make", {24'd0, last_make}, 32'h1C);
    @(negedge clk);
    check("lat_n4_valid", {31'd0, evt_valid}, 32'd0);
    repeat (4) @(negedge clk);
    check("lat_single_pulse", obs_q.size(), 32'd1);
    scan_ready = 1'b0;
    repeat (5) @(negedge clk);

    // Vector table
    for (int v = 0; v < 11; v++) begin
      obs_q.delete();
      for (int k = 0; k < vecs[v].n; k++) send_byte(vecs[v].b[k]);
      check($sformatf("vec%0d_count", v), obs_q.size(), 32'd1);
      if (obs_q.size() > 0)
        check($sformatf("vec%0d_event", v), {22'd0, obs_q[0]},
              {22'd0, vecs[v].ext, vecs[v].rel, vecs[v].code});
      if (!vecs[v].rel) check($sformatf("vec%0d_last", v), {24'd0, last_make}, {24'd0, vecs[v].code});
    end

    // Random byte stream against the model
    obs_q.delete();
    exp_q.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_last_make = last_make;
    for (int i = 0; i < 200; i++) begin
      logic [7:0] rb;
      logic [31:0] rv;
      rv = $urandom();
      case ($urandom_range(0, 3))
        0: rb = 8'hE0;
        1: rb = 8'hF0;
        default: rb = rv[7:0];
      endcase
      model_byte(rb);
      send_byte(rb);
    end
    compare_events("rand");
    check("rand_last_make", {24'd0, last_make}, {24'd0, m_last_make});
    check("rand_no_overflow", {31'd0, overflow}, 32'd0);

    // Consumer stalled: second event dropped, overflow sticky
    evt_ready = 1'b0;
    send_byte(8'h1C);
    send_byte(8'h32);
    check("ovf_valid", {31'd0, evt_valid}, 32'd1);
    check("ovf_code_held", {24'd0, evt_code}, 32'h1C);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    check("ovf_last_make", {24'd0, last_make}, 32'h32);
    @(negedge clk);
    evt_ready = 1'b1;
    @(negedge clk);
    check("ovf_accept_clears", {31'd0, evt_valid}, 32'd0);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Reset mid-sequence discards pending E0
    send_byte(8'hE0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("midrst");
    @(negedge clk);
    reset = 1'b0;
    obs_q.delete();
    exp_q.delete();
    exp_q.push_back({1'b0, 1'b0, 8'h75});
    send_byte(8'h75);
    compare_events("midrst_after");

    // Long gap after F0: timeout build abandons the prefix
    obs_q.delete();
    exp_q.delete();
    send_byte(8'hF0);
    repeat (20) @(negedge clk);
    send_byte(8'h1C);
`ifdef PS2_DECODE_TIMEOUT_EN
    exp_q.push_back({1'b0, 1'b0, 8'h1C});
`else
    exp_q.push_back({1'b0, 1'b1, 8'h1C});
`endif
    compare_events("timeout");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
